// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: walks the fetch address through instruction
// memory with a single outstanding req/gnt/rvalid transaction and hands each
// fetched word to decode over valid/ready. Handles redirects, squash and halt.
module fetch_ctrl #(
    parameter int unsigned              INSADDR_WIDTH = 32,
    parameter int unsigned              INSTR_WIDTH   = 32,
    parameter logic [INSADDR_WIDTH-1:0] RESET_ADDR    = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     halt,
    input  logic                     redir_valid,
    input  logic [INSADDR_WIDTH-1:0] redir_addr,
    output logic                     imem_req,
    output logic [INSADDR_WIDTH-1:0] imem_addr,
    input  logic                     imem_gnt,
    input  logic                     imem_rvalid,
    input  logic [INSTR_WIDTH-1:0]   imem_rdata,
    output logic                     instr_valid,
    output logic [INSTR_WIDTH-1:0]   instr_data,
    output logic [INSADDR_WIDTH-1:0] instr_addr,
    input  logic                     instr_ready,
    output logic                     busy
);

    localparam int unsigned AW = INSADDR_WIDTH;
    localparam int unsigned DW = INSTR_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_REQ    = 3'd1,
        S_WAIT   = 3'd2,
        S_HOLD   = 3'd3,
        S_HALTED = 3'd4
    } state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   fetch_addr_q, fetch_addr_d;
    logic [AW-1:0]   inflight_addr_q, inflight_addr_d;
    logic            kill_q, kill_d;
    logic            halt_pend_q, halt_pend_d;

    logic            imem_req_q, imem_req_d;
    logic [AW-1:0]   imem_addr_q, imem_addr_d;
    logic            instr_valid_q, instr_valid_d;
    logic [DW-1:0]   instr_data_q, instr_data_d;
    logic [AW-1:0]   instr_addr_q, instr_addr_d;
    logic            busy_q, busy_d;

    // A halt arriving in the same cycle as a transaction boundary counts too.
    logic            halt_eff;
    logic            deliver;
    logic            in_busy_state;

    assign halt_eff      = halt_pend_q | halt;
    assign in_busy_state = (state_q == S_REQ) || (state_q == S_WAIT) || (state_q == S_HOLD);
    assign deliver       = (state_q == S_WAIT) && imem_rvalid && !kill_q && !redir_valid;

    // State and control registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= S_IDLE;
            fetch_addr_q    <= RESET_ADDR;
            inflight_addr_q <= '0;
            kill_q          <= 1'b0;
            halt_pend_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            fetch_addr_q    <= fetch_addr_d;
            inflight_addr_q <= inflight_addr_d;
            kill_q          <= kill_d;
            halt_pend_q     <= halt_pend_d;
        end
    end

    // Next-state, fetch address, squash and halt bookkeeping.
    always_comb begin
        state_d         = state_q;
        fetch_addr_d    = fetch_addr_q;
        inflight_addr_d = inflight_addr_q;
        kill_d          = kill_q;
        halt_pend_d     = halt_pend_q;

        unique case (state_q)
            S_IDLE, S_HALTED: begin
                if (start && !halt) begin
                    state_d     = S_REQ;
                    halt_pend_d = 1'b0;
                end
            end
            S_REQ: begin
                if (imem_gnt) begin
                    inflight_addr_d = fetch_addr_q;
                    fetch_addr_d    = fetch_addr_q + AW'(1);
                    kill_d          = redir_valid;
                    state_d         = S_WAIT;
                end else if (halt_eff) begin
                    state_d = S_HALTED;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    if (kill_q || redir_valid) begin
                        kill_d  = 1'b0;
                        state_d = halt_eff ? S_HALTED : S_REQ;
                    end else begin
                        state_d = S_HOLD;
                    end
                end else if (redir_valid) begin
                    kill_d = 1'b1;
                end
            end
            S_HOLD: begin
                if (redir_valid || instr_ready) begin
                    state_d = halt_eff ? S_HALTED : S_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Redirect always overrides the sequential increment.
        if (redir_valid) begin
            fetch_addr_d = redir_addr;
        end
        if (halt && in_busy_state) begin
            halt_pend_d = 1'b1;
        end
    end

    // Output next values, derived from the upcoming state.
    always_comb begin
        imem_req_d    = (state_d == S_REQ);
        imem_addr_d   = fetch_addr_d;
        busy_d        = (state_d == S_REQ) || (state_d == S_WAIT) || (state_d == S_HOLD);
        instr_valid_d = instr_valid_q;
        instr_data_d  = instr_data_q;
        instr_addr_d  = instr_addr_q;

        if (deliver) begin
            instr_valid_d = 1'b1;
            instr_data_d  = imem_rdata;
            instr_addr_d  = inflight_addr_q;
        end else if ((state_q == S_HOLD) && (redir_valid || instr_ready)) begin
            instr_valid_d = 1'b0;
        end
    end

    // Registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imem_req_q    <= 1'b0;
            imem_addr_q   <= RESET_ADDR;
            busy_q        <= 1'b0;
            instr_valid_q <= 1'b0;
            instr_data_q  <= '0;
            instr_addr_q  <= '0;
        end else begin
            imem_req_q    <= imem_req_d;
            imem_addr_q   <= imem_addr_d;
            busy_q        <= busy_d;
            instr_valid_q <= instr_valid_d;
            instr_data_q  <= instr_data_d;
            instr_addr_q  <= instr_addr_d;
        end
    end

    assign imem_req    = imem_req_q;
    assign imem_addr   = imem_addr_q;
    assign busy        = busy_q;
    assign instr_valid = instr_valid_q;
    assign instr_data  = instr_data_q;
    assign instr_addr  = instr_addr_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a transaction-level model.
module tb_fetch_ctrl;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start, halt, redir_valid;
    logic [AW-1:0] redir_addr;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_gnt, imem_rvalid;
    logic [DW-1:0] imem_rdata;
    logic          instr_valid;
    logic [DW-1:0] instr_data;
    logic [AW-1:0] instr_addr;
    logic          instr_ready;
    logic          busy;

    always #5 clk = ~clk;

    fetch_ctrl #(
        .INSADDR_WIDTH(AW),
        .INSTR_WIDTH  (DW),
        .RESET_ADDR   (32'h0)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .halt       (halt),
        .redir_valid(redir_valid),
        .redir_addr (redir_addr),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_gnt   (imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .instr_valid(instr_valid),
        .instr_data (instr_data),
        .instr_addr (instr_addr),
        .instr_ready(instr_ready),
        .busy       (busy)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Transaction-level reference: fetching or not, a memory transaction
    // outstanding or not, an instruction presented or not.
    typedef struct packed {
        logic        active;
        logic        outst;
        logic        squash;
        logic        pres;
        logic        hp;
        logic [31:0] pc;
        logic [31:0] inaddr;
        logic [31:0] idata;
        logic [31:0] iaddr;
    } model_t;

    model_t m;

    function automatic model_t model_step(input model_t c, input logic st, input logic hl,
                                          input logic rv, input logic [31:0] ra,
                                          input logic gnt, input logic rvld,
                                          input logic [31:0] rd, input logic rdy);
        model_t n;
        logic   hpe;
        n   = c;
        hpe = c.hp | hl;
        if (!c.active) begin
            if (st && !hl) begin
                n.active = 1'b1;
                n.hp     = 1'b0;
            end
            if (rv) n.pc = ra;
        end else begin
            if (!c.outst && !c.pres) begin
                if (gnt) begin
                    n.outst  = 1'b1;
                    n.inaddr = c.pc;
                    n.squash = rv;
                    n.pc     = rv ? ra : c.pc + 32'd1;
                end else begin
                    if (rv) n.pc = ra;
                    if (hpe) n.active = 1'b0;
                end
            end else if (c.outst) begin
                if (rv) n.pc = ra;
                if (rvld) begin
                    n.outst = 1'b0;
                    if (c.squash || rv) begin
                        n.squash = 1'b0;
                        if (hpe) n.active = 1'b0;
                    end else begin
                        n.pres  = 1'b1;
                        n.idata = rd;
                        n.iaddr = c.inaddr;
                    end
                end else if (rv) begin
                    n.squash = 1'b1;
                end
            end else begin
                if (rv) n.pc = ra;
                if (rv || rdy) begin
                    n.pres = 1'b0;
                    if (hpe) n.active = 1'b0;
                end
            end
            if (hl) n.hp = 1'b1;
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= '0;
        else m <= model_step(m, start, halt, redir_valid, redir_addr,
                             imem_gnt, imem_rvalid, imem_rdata, instr_ready);
    end

    // Log of accepted requests and completed handshakes, for directed checks.
    logic [31:0] gnt_q[$];
    logic [31:0] hs_q[$];
    logic [31:0] hsd_q[$];
    int          hsc_q[$];

    always @(negedge clk) begin
        if (rst_n === 1'b1 && imem_req && imem_gnt) gnt_q.push_back(imem_addr);
        if (rst_n === 1'b1 && instr_valid && instr_ready) begin
            hs_q.push_back(instr_addr);
            hsd_q.push_back(instr_data);
            hsc_q.push_back(cyc);
        end
    end

    // Instruction memory: grants, fixed or random latency, optional junk.
    logic        mem_auto;
    int          gnt_pct, lat_min, lat_max;
    logic        spur, force_rv;
    logic        pend;
    int          cnt;
    logic [31:0] paddr;

    initial begin
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        pend        = 1'b0;
        cnt         = 0;
        paddr       = '0;
        forever begin
            @(posedge clk);
            #2;
            imem_gnt    = 1'b0;
            imem_rvalid = 1'b0;
            if (!mem_auto) begin
                pend        = 1'b0;
                imem_rvalid = force_rv;
                imem_rdata  = 32'hDEAD_BEEF;
            end else if (!rst_n) begin
                pend = 1'b0;
            end else begin
                if (pend) begin
                    if (cnt == 0) begin
                        imem_rvalid = 1'b1;
                        imem_rdata  = mem_word(paddr);
                        pend        = 1'b0;
                    end else begin
                        cnt--;
                    end
                end else if (spur && $urandom_range(0, 19) == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = $urandom;
                end
                if (imem_req && !pend && !imem_rvalid &&
                    $urandom_range(0, 99) < gnt_pct) begin
                    imem_gnt = 1'b1;
                    pend     = 1'b1;
                    paddr    = imem_addr;
                    cnt      = $urandom_range(lat_min, lat_max);
                end else if (spur && !imem_req && $urandom_range(0, 19) == 0) begin
                    imem_gnt = 1'b1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_hs(input int want, input int max, input string nm);
        int k = 0;
        while (hs_q.size() < want && k < max) begin tick(); k++; end
        chk(nm, 64'(hs_q.size() >= want), 64'd1);
    endtask

    task automatic wait_gnt(input int want, input int max, input string nm);
        int k = 0;
        while (gnt_q.size() < want && k < max) begin tick(); k++; end
        chk(nm, 64'(gnt_q.size() >= want), 64'd1);
    endtask

    task automatic wait_idle(input int max, input string nm);
        int k = 0;
        while (busy && k < max) begin tick(); k++; end
        chk(nm, 64'(busy), 64'd0);
    endtask

    initial begin
        int gb, hb, c0, k;
        logic [31:0] ga;
        rst_n = 1'b0; start = 1'b0; halt = 1'b0; redir_valid = 1'b0;
        redir_addr = '0; instr_ready = 1'b1;
        mem_auto = 1'b1; gnt_pct = 100; lat_min = 0; lat_max = 0;
        spur = 1'b0; force_rv = 1'b0;

        // Per-cycle comparison against the model.
        fork
            forever begin
                @(negedge clk);
                chk("busy", 64'(busy), 64'(m.active));
                chk("imem_req", 64'(imem_req), 64'(m.active && !m.outst && !m.pres));
                if (m.active && !m.outst && !m.pres) chk("imem_addr", 64'(imem_addr), 64'(m.pc));
                chk("instr_valid", 64'(instr_valid), 64'(m.pres));
                chk("instr_data", 64'(instr_data), 64'(m.idata));
                chk("instr_addr", 64'(instr_addr), 64'(m.iaddr));
            end
        join_none

        repeat (3) @(posedge clk);
        #1;
        chk("rst_req", 64'(imem_req), 64'd0);
        chk("rst_valid", 64'(instr_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_data", 64'(instr_data), 64'd0);
        chk("rst_iaddr", 64'(instr_addr), 64'd0);
        rst_n = 1'b1;
        tick();

        // Zero-wait streaming from address 0.
        start = 1'b1; c0 = cyc; tick(); start = 1'b0;
        wait_hs(4, 40, "t1_timeout");
        for (int i = 0; i < 4 && i < hs_q.size(); i++) begin
            chk("t1_gnt_addr", 64'(gnt_q[i]), 64'(i));
            chk("t1_instr_addr", 64'(hs_q[i]), 64'(i));
            chk("t1_instr_data", 64'(hsd_q[i]), 64'(mem_word(32'(i))));
        end
        if (hs_q.size() >= 4) begin
            chk("t1_first_latency", 64'(hsc_q[0] - c0), 64'd3);
            for (int i = 1; i < 4; i++) chk("t1_period", 64'(hsc_q[i] - hsc_q[i-1]), 64'd3);
        end

        // Backpressure on address 4.
        instr_ready = 1'b0;
        k = 0;
        while (!instr_valid && k < 10) begin tick(); k++; end
        for (int j = 0; j < 5; j++) begin
            chk("t2_valid_held", 64'(instr_valid), 64'd1);
            chk("t2_addr_held", 64'(instr_addr), 64'd4);
            chk("t2_data_held", 64'(instr_data), 64'(mem_word(32'd4)));
            chk("t2_no_req", 64'(imem_req), 64'd0);
            tick();
        end
        gb = gnt_q.size();
        instr_ready = 1'b1;
        wait_gnt(gb + 1, 20, "t2_timeout");
        if (gnt_q.size() > gb) chk("t2_next_req", 64'(gnt_q[gb]), 64'd5);

        // Redirect during WAIT for address 7.
        lat_min = 2; lat_max = 2;
        k = 0;
        while (!(gnt_q.size() > 0 && gnt_q[$] == 32'd7) && k < 60) begin tick(); k++; end
        chk("t3_reach7", 64'(gnt_q[$]), 64'd7);
        hb = hs_q.size(); gb = gnt_q.size();
        redir_valid = 1'b1; redir_addr = 32'h100; tick(); redir_valid = 1'b0;
        wait_hs(hb + 1, 30, "t3_timeout");
        if (hs_q.size() > hb) chk("t3_instr_addr", 64'(hs_q[hb]), 64'h100);
        if (gnt_q.size() > gb) chk("t3_next_req", 64'(gnt_q[gb]), 64'h100);

        // Redirect coincident with the grant of 0x102.
        k = 0;
        while (!(imem_req && imem_addr == 32'h102) && k < 40) begin tick(); k++; end
        hb = hs_q.size(); gb = gnt_q.size();
        redir_valid = 1'b1; redir_addr = 32'h100; tick(); redir_valid = 1'b0;
        wait_hs(hb + 1, 30, "t3b_timeout");
        if (gnt_q.size() > gb + 1) begin
            chk("t3b_squashed_req", 64'(gnt_q[gb]), 64'h102);
            chk("t3b_next_req", 64'(gnt_q[gb+1]), 64'h100);
        end
        if (hs_q.size() > hb) chk("t3b_instr_addr", 64'(hs_q[hb]), 64'h100);

        // Redirect in HOLD with a simultaneous handshake.
        instr_ready = 1'b0;
        redir_valid = 1'b1; redir_addr = 32'd9; tick(); redir_valid = 1'b0;
        k = 0;
        while (!(instr_valid && instr_addr == 32'd9) && k < 30) begin tick(); k++; end
        hb = hs_q.size(); gb = gnt_q.size();
        instr_ready = 1'b1; redir_valid = 1'b1; redir_addr = 32'h40; tick(); redir_valid = 1'b0;
        wait_hs(hb + 2, 30, "t4_timeout");
        if (hs_q.size() > hb + 1) begin
            chk("t4_consumed", 64'(hs_q[hb]), 64'd9);
            chk("t4_after", 64'(hs_q[hb+1]), 64'h40);
        end
        if (gnt_q.size() > gb) chk("t4_next_req", 64'(gnt_q[gb]), 64'h40);

        // Halt during WAIT: deliver, then stop.
        gb = gnt_q.size();
        wait_gnt(gb + 1, 20, "t5_gnt_timeout");
        ga = gnt_q[$];
        hb = hs_q.size();
        halt = 1'b1; tick(); halt = 1'b0;
        wait_hs(hb + 1, 20, "t5_deliver_timeout");
        if (hs_q.size() > hb) begin
            chk("t5_delivered_addr", 64'(hs_q[hb]), 64'(ga));
            chk("t5_delivered_data", 64'(hsd_q[hb]), 64'(mem_word(ga)));
        end
        wait_idle(10, "t5_halt_timeout");
        gb = gnt_q.size();
        for (int j = 0; j < 4; j++) begin
            chk("t5_halted_busy", 64'(busy), 64'd0);
            chk("t5_halted_req", 64'(imem_req), 64'd0);
            tick();
        end
        chk("t5_no_gnt_halted", 64'(gnt_q.size()), 64'(gb));
        hb = hs_q.size();
        redir_valid = 1'b1; redir_addr = 32'h20; start = 1'b1; tick();
        redir_valid = 1'b0; start = 1'b0;
        wait_hs(hb + 1, 20, "t5_resume_timeout");
        if (gnt_q.size() > gb) chk("t5_resume_req", 64'(gnt_q[gb]), 64'h20);
        if (hs_q.size() > hb) chk("t5_resume_instr", 64'(hs_q[hb]), 64'h20);

        // Address wrap at the top of the space.
        halt = 1'b1; tick(); halt = 1'b0;
        wait_idle(20, "t6_halt_timeout");
        gb = gnt_q.size();
        redir_valid = 1'b1; redir_addr = 32'hFFFF_FFFE; start = 1'b1; tick();
        redir_valid = 1'b0; start = 1'b0;
        wait_gnt(gb + 3, 40, "t6_wrap_timeout");
        if (gnt_q.size() > gb + 2) begin
            chk("t6_wrap0", 64'(gnt_q[gb]), 64'hFFFF_FFFE);
            chk("t6_wrap1", 64'(gnt_q[gb+1]), 64'hFFFF_FFFF);
            chk("t6_wrap2", 64'(gnt_q[gb+2]), 64'h0);
        end

        // Asynchronous reset in the middle of WAIT, then a stale response.
        lat_min = 3; lat_max = 3;
        gb = gnt_q.size();
        wait_gnt(gb + 1, 20, "t6_gnt_timeout");
        #2;
        mem_auto = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_req", 64'(imem_req), 64'd0);
        chk("t6_rst_busy", 64'(busy), 64'd0);
        chk("t6_rst_valid", 64'(instr_valid), 64'd0);
        chk("t6_rst_data", 64'(instr_data), 64'd0);
        chk("t6_rst_iaddr", 64'(instr_addr), 64'd0);
        tick(); tick();
        rst_n = 1'b1; force_rv = 1'b1; tick(); force_rv = 1'b0;
        for (int j = 0; j < 3; j++) begin
            chk("t6_stale_valid", 64'(instr_valid), 64'd0);
            chk("t6_stale_busy", 64'(busy), 64'd0);
            tick();
        end

        // Randomized traffic against the model.
        mem_auto = 1'b1; spur = 1'b1; gnt_pct = 60; lat_min = 0; lat_max = 2;
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            instr_ready = ($urandom_range(0, 9) < 7);
            start       = ($urandom_range(0, 19) == 0);
            halt        = ($urandom_range(0, 39) == 0);
            redir_valid = ($urandom_range(0, 19) == 0);
            redir_addr  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3))
                                                       : 32'($urandom);
            if (i == 1500) rst_n = 1'b0;
            if (i == 1502) rst_n = 1'b1;
            tick();
        end
        start = 1'b0; halt = 1'b0; redir_valid = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
